vga_timing_porch_gen: RTL and testbench

Self-contained, fully parametrised VGA timing generator with a built-in front/back porch and a video alignment pipeline. It owns its own H/V counters, so no external sync source is needed. It drives pixel coordinates to the pattern/sprite logic and accepts that logic's video after a fixed, parametrised latency. It then emits HSync, VSync, DE and blanked RGB, all on the same cycle. It sits directly in front of the VGA pins and replaces the "sync generator plus porch adjuster" pair.

---
 rtl/vga_timing_porch_gen.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_porch_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_porch_gen.sv
// VGA timing generator with built-in porches, sync polarity control and a
// latency-matched pipeline that aligns sync/DE with blanked pattern video.
module vga_timing_porch_gen #(
   parameter int   VIDEO_WIDTH = 3,
   parameter int   COUNT_WIDTH = 10,
   parameter int   H_ACTIVE    = 640,
   parameter int   H_FRONT     = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BACK      = 48,
   parameter int   V_ACTIVE    = 480,
   parameter int   V_FRONT     = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BACK      = 33,
   parameter logic H_SYNC_POL  = 1'b0,
   parameter logic V_SYNC_POL  = 1'b0,
   parameter int   VIDEO_DELAY = 2
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_L,
   input  logic                   i_Enable,
   input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
   input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
   input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
   output logic [COUNT_WIDTH-1:0] o_Col_Count,
   output logic [COUNT_WIDTH-1:0] o_Row_Count,
   output logic                   o_HSync,
   output logic                   o_VSync,
   output logic                   o_DE,
   output logic                   o_Frame_Start,
   output logic [VIDEO_WIDTH-1:0] o_Red_Video,
   output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
   output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Region bounds carry one spare bit so a sync region ending exactly at
   // 2**COUNT_WIDTH still compares correctly.
   localparam int XW = COUNT_WIDTH + 1;
   localparam logic [COUNT_WIDTH-1:0] H_LAST       = COUNT_WIDTH'(H_TOTAL - 1);
   localparam logic [COUNT_WIDTH-1:0] V_LAST       = COUNT_WIDTH'(V_TOTAL - 1);
   localparam logic [XW-1:0]          H_ACT_X      = XW'(H_ACTIVE);
   localparam logic [XW-1:0]          H_SYNC_BEG_X = XW'(H_ACTIVE + H_FRONT);
   localparam logic [XW-1:0]          H_SYNC_END_X = XW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [XW-1:0]          V_ACT_X      = XW'(V_ACTIVE);
   localparam logic [XW-1:0]          V_SYNC_BEG_X = XW'(V_ACTIVE + V_FRONT);
   localparam logic [XW-1:0]          V_SYNC_END_X = XW'(V_ACTIVE + V_FRONT + V_SYNC);

   generate
      if (H_SYNC <= 0 || V_SYNC <= 0) begin : g_bad_sync
         $fatal(1, "vga_timing_porch_gen: H_SYNC and V_SYNC must be non-zero");
      end
      if (H_ACTIVE <= 0 || V_ACTIVE <= 0) begin : g_bad_active
         $fatal(1, "vga_timing_porch_gen: active area must be non-empty");
      end
      if ((H_TOTAL - 1) >= (1 << COUNT_WIDTH) || (V_TOTAL - 1) >= (1 << COUNT_WIDTH)) begin : g_bad_width
         $fatal(1, "vga_timing_porch_gen: COUNT_WIDTH too small for H_TOTAL/V_TOTAL");
      end
      if (VIDEO_DELAY < 0 || VIDEO_DELAY > 15) begin : g_bad_delay
         $fatal(1, "vga_timing_porch_gen: VIDEO_DELAY must be within 0..15");
      end
   endgenerate

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic fs;
   } timing_t;

   logic [COUNT_WIDTH-1:0] col_reg;
   logic [COUNT_WIDTH-1:0] col_next;
   logic [COUNT_WIDTH-1:0] row_reg;
   logic [COUNT_WIDTH-1:0] row_next;
   logic [XW-1:0]          col_ext;
   logic [XW-1:0]          row_ext;
   timing_t                stage0;
   timing_t                tap [VIDEO_DELAY+1];
   timing_t                aligned;

   logic                   hsync_reg;
   logic                   vsync_reg;
   logic                   de_reg;
   logic                   fs_reg;
   logic [VIDEO_WIDTH-1:0] red_reg;
   logic [VIDEO_WIDTH-1:0] grn_reg;
   logic [VIDEO_WIDTH-1:0] blu_reg;

   // Raster counters; disabling parks them at the origin.
   always_comb begin
      col_next = col_reg;
      row_next = row_reg;
      if (!i_Enable) begin
         col_next = '0;
         row_next = '0;
      end else if (col_reg == H_LAST) begin
         col_next = '0;
         row_next = (row_reg == V_LAST) ? '0 : row_reg + COUNT_WIDTH'(1);
      end else begin
         col_next = col_reg + COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         col_reg <= '0;
         row_reg <= '0;
      end else begin
         col_reg <= col_next;
         row_reg <= row_next;
      end
   end

   assign col_ext = {1'b0, col_reg};
   assign row_ext = {1'b0, row_reg};

   // Stage-0 decode holds logical (polarity-free) flags; idle while disabled.
   always_comb begin
      stage0 = '0;
      if (i_Enable) begin
         stage0.hs = (col_ext >= H_SYNC_BEG_X) && (col_ext < H_SYNC_END_X);
         stage0.vs = (row_ext >= V_SYNC_BEG_X) && (row_ext < V_SYNC_END_X);
         stage0.de = (col_ext < H_ACT_X) && (row_ext < V_ACT_X);
         stage0.fs = (col_reg == '0) && (row_reg == '0);
      end
   end

   assign tap[0] = stage0;

   // Delay line matching the pattern logic latency; keeps shifting when
   // disabled so pixels already requested still reach the pins.
   generate
      for (genvar gi = 0; gi < VIDEO_DELAY; gi++) begin : g_stage
         timing_t stage_reg;
         always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
               stage_reg <= '0;
            end else begin
               stage_reg <= tap[gi];
            end
         end
         assign tap[gi+1] = stage_reg;
      end
   endgenerate

   assign aligned = tap[VIDEO_DELAY];

   // Output register: polarity applied here, video registered once and blanked.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         hsync_reg <= ~H_SYNC_POL;
         vsync_reg <= ~V_SYNC_POL;
         de_reg    <= 1'b0;
         fs_reg    <= 1'b0;
         red_reg   <= '0;
         grn_reg   <= '0;
         blu_reg   <= '0;
      end else begin
         hsync_reg <= aligned.hs ? H_SYNC_POL : ~H_SYNC_POL;
         vsync_reg <= aligned.vs ? V_SYNC_POL : ~V_SYNC_POL;
         de_reg    <= aligned.de;
         fs_reg    <= aligned.fs;
         red_reg   <= aligned.de ? i_Red_Video : '0;
         grn_reg   <= aligned.de ? i_Grn_Video : '0;
         blu_reg   <= aligned.de ? i_Blu_Video : '0;
      end
   end

   assign o_Col_Count   = col_reg;
   assign o_Row_Count   = row_reg;
   assign o_HSync       = hsync_reg;
   assign o_VSync       = vsync_reg;
   assign o_DE          = de_reg;
   assign o_Frame_Start = fs_reg;
   assign o_Red_Video   = red_reg;
   assign o_Grn_Video   = grn_reg;
   assign o_Blu_Video   = blu_reg;

endmodule

// File: tb/tb_vga_timing_porch_gen.sv
// Directed bench: tiny 8x6 raster for cycle-exact checks plus a default
// 640x480 instance for line-level sync/DE counts.
`timescale 1ns/1ps
module tb_vga_timing_porch_gen;

   localparam int VW = 3;
   localparam int CW = 4;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          en     = 1'b1;
   logic [VW-1:0] red_in = '0;
   logic [VW-1:0] grn_in = 3'd5;
   logic [VW-1:0] blu_in = 3'd2;
   logic [CW-1:0] col;
   logic [CW-1:0] row;
   logic          hs, vs, de, fs;
   logic [VW-1:0] red_out, grn_out, blu_out;

   logic          d_en  = 1'b1;
   logic [VW-1:0] d_red = '0;
   logic [VW-1:0] d_grn = '0;
   logic [VW-1:0] d_blu = '0;
   logic [9:0]    d_col, d_row;
   logic          d_hs, d_vs, d_de, d_fs;
   logic [VW-1:0] d_red_out, d_grn_out, d_blu_out;

   int total = 0;
   int bad   = 0;
   int since = 0;
   logic [CW-1:0] hist0 = '0;
   logic [CW-1:0] hist1 = '0;
   logic [CW-1:0] hist2 = '0;

   always #5 clk = ~clk;

   vga_timing_porch_gen #(
      .VIDEO_WIDTH(VW), .COUNT_WIDTH(CW),
      .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .VIDEO_DELAY(2)
   ) dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
      .i_Red_Video(red_in), .i_Grn_Video(grn_in), .i_Blu_Video(blu_in),
      .o_Col_Count(col), .o_Row_Count(row),
      .o_HSync(hs), .o_VSync(vs), .o_DE(de), .o_Frame_Start(fs),
      .o_Red_Video(red_out), .o_Grn_Video(grn_out), .o_Blu_Video(blu_out)
   );

   vga_timing_porch_gen dut_640 (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(d_en),
      .i_Red_Video(d_red), .i_Grn_Video(d_grn), .i_Blu_Video(d_blu),
      .o_Col_Count(d_col), .o_Row_Count(d_row),
      .o_HSync(d_hs), .o_VSync(d_vs), .o_DE(d_de), .o_Frame_Start(d_fs),
      .o_Red_Video(d_red_out), .o_Grn_Video(d_grn_out), .o_Blu_Video(d_blu_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Plays the pattern logic: red = column requested two clocks ago, or 7
   // when that column is outside the active width.
   task automatic tick();
      @(posedge clk);
      #1;
      hist2  = hist1;
      hist1  = hist0;
      hist0  = col;
      red_in = (hist2 < 4) ? hist2[VW-1:0] : 3'd7;
   endtask

   task automatic run_check(input int n);
      int p, c, r;
      logic e_hs, e_vs, e_de, e_fs;
      logic [VW-1:0] e_red, e_grn, e_blu;
      for (int k = 0; k < n; k++) begin
         tick();
         since++;
         p = since - 3;
         c = 0;
         r = 0;
         e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0;
         if (p >= 0) begin
            c = p % 8;
            r = (p / 8) % 6;
            e_hs = !(c == 5 || c == 6);
            e_vs = (r != 4);
            e_de = (c < 4) && (r < 3);
            e_fs = ((p % 48) == 0);
         end
         e_red = e_de ? VW'(c) : '0;
         e_grn = e_de ? 3'd5 : '0;
         e_blu = e_de ? 3'd2 : '0;
         $display("since=%0d col=%0d row=%0d hs=%b vs=%b de=%b fs=%b rgb=%0d/%0d/%0d",
                  since, col, row, hs, vs, de, fs, red_out, grn_out, blu_out);
         chk($sformatf("col@%0d", since), 32'(col), 32'(since % 8));
         chk($sformatf("row@%0d", since), 32'(row), 32'((since / 8) % 6));
         chk($sformatf("hsync@%0d", since), 32'(hs), 32'(e_hs));
         chk($sformatf("vsync@%0d", since), 32'(vs), 32'(e_vs));
         chk($sformatf("de@%0d", since), 32'(de), 32'(e_de));
         chk($sformatf("fs@%0d", since), 32'(fs), 32'(e_fs));
         chk($sformatf("red@%0d", since), 32'(red_out), 32'(e_red));
         chk($sformatf("grn@%0d", since), 32'(grn_out), 32'(e_grn));
         chk($sformatf("blu@%0d", since), 32'(blu_out), 32'(e_blu));
      end
   endtask

   task automatic check_idle(input string tag);
      $display("%s col=%0d row=%0d hs=%b vs=%b de=%b fs=%b red=%0d",
               tag, col, row, hs, vs, de, fs, red_out);
      chk({tag, "_col"}, 32'(col), 32'd0);
      chk({tag, "_row"}, 32'(row), 32'd0);
      chk({tag, "_hs"}, 32'(hs), 32'd1);
      chk({tag, "_vs"}, 32'(vs), 32'd1);
      chk({tag, "_de"}, 32'(de), 32'd0);
      chk({tag, "_fs"}, 32'(fs), 32'd0);
      chk({tag, "_red"}, 32'(red_out), 32'd0);
   endtask

   task automatic default_window(input string tag);
      int hs_low = 0;
      int de_hi  = 0;
      int vs_low = 0;
      int fs_cnt = 0;
      for (int k = 0; k < 800; k++) begin
         tick();
         since++;
         if (d_hs === 1'b0) hs_low++;
         if (d_de === 1'b1) de_hi++;
         if (d_vs === 1'b0) vs_low++;
         if (d_fs === 1'b1) fs_cnt++;
      end
      $display("%s hs_low=%0d de_hi=%0d vs_low=%0d fs=%0d", tag, hs_low, de_hi, vs_low, fs_cnt);
      chk({tag, "_hs_low"}, 32'(hs_low), 32'd96);
      chk({tag, "_de_hi"}, 32'(de_hi), 32'd640);
      chk({tag, "_vs_low"}, 32'(vs_low), 32'd0);
      chk({tag, "_fs"}, 32'(fs_cnt), 32'd0);
   endtask

   initial begin
      // Reset held for five clocks.
      for (int k = 0; k < 5; k++) begin
         tick();
         check_idle($sformatf("reset%0d", k));
         chk($sformatf("reset%0d_grn", k), 32'(grn_out), 32'd0);
      end
      rst_n = 1'b1;
      since = 0;

      // Free run to column 2 of row 1, covering the (7,5)->(0,0) wrap.
      run_check(58);

      // Enable drop: two issued pixels drain, then everything idles.
      en = 1'b0;
      tick();
      $display("drain1 col=%0d row=%0d de=%b red=%0d", col, row, de, red_out);
      chk("drain1_col", 32'(col), 32'd0);
      chk("drain1_row", 32'(row), 32'd0);
      chk("drain1_de", 32'(de), 32'd1);
      chk("drain1_red", 32'(red_out), 32'd0);
      tick();
      $display("drain2 col=%0d row=%0d de=%b red=%0d", col, row, de, red_out);
      chk("drain2_de", 32'(de), 32'd1);
      chk("drain2_red", 32'(red_out), 32'd1);
      chk("drain2_grn", 32'(grn_out), 32'd5);
      for (int k = 0; k < 4; k++) begin
         tick();
         check_idle($sformatf("disabled%0d", k));
      end

      // Re-enable: frame start three clocks after counters read (0,0).
      en = 1'b1;
      since = 0;
      run_check(85);

      // Asynchronous reset in the VSync row clears outputs immediately.
      chk("pre_reset_vs", 32'(vs), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("async_reset");
      tick();
      check_idle("reset_hold");
      rst_n = 1'b1;
      since = 0;
      run_check(10);

      // Default 640x480 timing, two consecutive 800-clock windows.
      default_window("line_a");
      default_window("line_b");
      chk("d_col", 32'(d_col), 32'd10);
      chk("d_row", 32'(d_row), 32'd2);
      chk("d_vs", 32'(d_vs), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
